alu_sched: RTL and testbench

Two-requester scheduler that time-shares one instance of the team's 6-bit `ALU` (ADD/SUB/MUL/AND). Each requester issues operations through a valid/ready handshake. The block arbitrates round-robin, registers the operands, and holds them stable for the ALU for a per-op number of cycles so the Wallace multiplier path gets multicycle timing. It then returns the registered, requester-tagged result on a single valid/ready response channel.

---
 rtl/alu_sched_pkg.sv | 10 +
 rtl/alu_sched_if.sv | 23 ++
 rtl/ALU.sv | 23 ++
 rtl/alu_sched.sv | 76 +++++++
 tb/tb_alu_sched.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: FSM states, ALU op encodings and limits shared by the scheduler
package alu_sched_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;
  localparam int MUL_WAIT_MAX = 15;
  localparam int CNT_W = 4;
endpackage

// File: rtl/alu_sched_if.sv
// alu_sched_if: two request channels plus one tagged response channel
interface alu_sched_if;
  logic       req0_valid, req0_ready, req0_cin;
  logic [5:0] req0_a, req0_b;
  logic [1:0] req0_sel;
  logic       req1_valid, req1_ready, req1_cin;
  logic [5:0] req1_a, req1_b;
  logic [1:0] req1_sel;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_carry, busy;
  logic [11:0] rsp_result;
  modport master (
    output req0_valid, req0_a, req0_b, req0_sel, req0_cin,
    output req1_valid, req1_a, req1_b, req1_sel, req1_cin,
    output rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, busy
  );
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel, req0_cin,
    input  req1_valid, req1_a, req1_b, req1_sel, req1_cin,
    input  rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, busy
  );
endinterface

// File: rtl/ALU.sv
// ALU: 6-bit ADD/SUB/MUL/AND; carry is borrow for SUB, 0 for MUL/AND
module ALU
  import alu_sched_pkg::*;
(
  input  logic [5:0]  a,
  input  logic [5:0]  b,
  input  logic [1:0]  sel,
  input  logic        cin,
  output logic [11:0] result,
  output logic        carry_out
);
  logic [6:0]  sum, dif;
  logic [11:0] prod;
  always_comb begin
    sum = {1'b0, a} + {1'b0, b} + {6'd0, cin};
    dif = {1'b0, a} - {1'b0, b} - {6'd0, cin};
    prod = {6'd0, a} * {6'd0, b};
    result = sel == OP_MUL ? prod :
             sel == OP_AND ? {6'd0, a & b} :
             {6'd0, sel == OP_SUB ? dif[5:0] : sum[5:0]};
    carry_out = sel == OP_ADD ? sum[6] : sel == OP_SUB ? dif[6] : 1'b0;
  end
endmodule

// File: rtl/alu_sched.sv
// alu_sched: round-robin two-requester scheduler time-sharing one ALU
// with per-op multicycle operand hold and a registered tagged response.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int MUL_WAIT = 2
) (
  input logic        clk,
  input logic        rst_n,
  alu_sched_if.slave bus
);
  state_t state, nxt;
  logic last, gnt1, take, id_q, cin_q, alu_carry;
  logic [5:0] a_q, b_q;
  logic [1:0] sel_q, sel_n;
  logic [CNT_W-1:0] cnt;
  logic [11:0] alu_result;
  if (MUL_WAIT < 1 || MUL_WAIT > MUL_WAIT_MAX) begin : g_bad_wait
    $error("alu_sched: MUL_WAIT out of range");
  end
  // ready is gated by rst_n so it drops together with the async reset
  always_comb begin
    nxt = state;
    gnt1 = bus.req1_valid && (!bus.req0_valid || !last);
    take = rst_n && state == IDLE && (bus.req0_valid || bus.req1_valid);
    sel_n = gnt1 ? bus.req1_sel : bus.req0_sel;
    bus.req0_ready = take && !gnt1;
    bus.req1_ready = take && gnt1;
    bus.rsp_valid = state == RESP;
    bus.busy = state != IDLE;
    nxt = state == IDLE ? (take ? EXEC : IDLE) :
          state == EXEC ? (cnt == '0 ? RESP : EXEC) :
          (bus.rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
      id_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      sel_q <= OP_ADD;
      cin_q <= 1'b0;
      cnt <= '0;
      bus.rsp_id <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_carry <= 1'b0;
    end else if (take) begin
      last <= gnt1;
      id_q <= gnt1;
      a_q <= gnt1 ? bus.req1_a : bus.req0_a;
      b_q <= gnt1 ? bus.req1_b : bus.req0_b;
      sel_q <= sel_n;
      cin_q <= gnt1 ? bus.req1_cin : bus.req0_cin;
      cnt <= sel_n == OP_MUL ? CNT_W'(MUL_WAIT - 1) : '0;
    end else if (state == EXEC) begin
      if (cnt == '0) begin
        bus.rsp_id <= id_q;
        bus.rsp_result <= alu_result;
        bus.rsp_carry <= alu_carry;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end
  ALU u_alu (
    .a(a_q),
    .b(b_q),
    .sel(sel_q),
    .cin(cin_q),
    .result(alu_result),
    .carry_out(alu_carry)
  );
endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed table, stall/reset sequences and random traffic vs a behavioural model
module tb_alu_sched;
  import alu_sched_pkg::*;
  localparam int MW = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  alu_sched_if bus();
  alu_sched #(.MUL_WAIT(MW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // {carry, result} from the arithmetic definition of each op
  function automatic logic [12:0] model(input logic [5:0] a, input logic [5:0] b,
                                        input logic [1:0] sel, input logic cin);
    int r;
    case (sel)
      OP_ADD: begin r = int'(a) + int'(b) + int'(cin); return {r > 63, 12'(r % 64)}; end
      OP_SUB: begin r = int'(a) - int'(b) - int'(cin); return {r < 0, 12'((r + 64) % 64)}; end
      OP_MUL: return {1'b0, 12'(int'(a) * int'(b))};
      default: return {1'b0, 6'd0, a & b};
    endcase
  endfunction
  function automatic int lat(input logic [1:0] sel);
    return sel == OP_MUL ? MW : 1;
  endfunction

  task automatic drive_req(input int id, input logic v, input logic [5:0] a, input logic [5:0] b,
                           input logic [1:0] sel, input logic cin);
    if (id == 1) begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_sel = sel; bus.req1_cin = cin;
    end else begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_sel = sel; bus.req0_cin = cin;
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ready(input int id, output logic got, output int t);
    got = 1'b0;
    t = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((id == 1) ? bus.req1_ready : bus.req0_ready) begin
        got = 1'b1;
        t = cyc;
        break;
      end
      step();
    end
  endtask
  task automatic finish_rsp(input logic id, input logic [12:0] exp, input int t_acc, input int n);
    logic got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.rsp_valid) begin
        got = 1'b1;
        break;
      end
      step();
    end
    chk("rsp_seen", 32'(got), 32'd1);
    chk("latency", 32'(cyc - t_acc), 32'(n + 1));
    chk("rsp_id", 32'(bus.rsp_id), 32'(id));
    chk("rsp_result", 32'(bus.rsp_result), 32'(exp[11:0]));
    chk("rsp_carry", 32'(bus.rsp_carry), 32'(exp[12]));
    step();
    chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);
  endtask

  typedef struct {
    logic id; logic [5:0] a; logic [5:0] b; logic [1:0] sel; logic cin;
    logic [11:0] res; logic c;
  } vec_t;
  vec_t vt[10];
  logic tb_last = 1'b1;

  task automatic do_op(input vec_t v);
    logic got;
    int t;
    drive_req(int'(v.id), 1'b1, v.a, v.b, v.sel, v.cin);
    bus.rsp_ready = 1'b1;
    wait_ready(int'(v.id), got, t);
    chk("accept", 32'(got), 32'd1);
    step();
    drive_req(int'(v.id), 1'b0, '0, '0, OP_ADD, 1'b0);
    if (got) finish_rsp(v.id, {v.c, v.res}, t, lat(v.sel));
    tb_last = v.id;
  endtask

  // random traffic state: model of outstanding op and per-requester held payloads
  typedef struct { logic id; logic [12:0] exp; } sb_t;
  sb_t sbq[$];
  int gseq[$];
  logic out_busy = 1'b0;
  int rsp_due = 0;
  logic hold[2];
  logic [5:0] pa[2], pb[2];
  logic [1:0] psel[2];
  logic pcin[2];

  task automatic traffic(input int n, input int pv, input int pr);
    logic go;
    int w;
    sb_t s;
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < 2; i++)
        if (!hold[i] && $urandom_range(99) < pv) begin
          hold[i] = 1'b1;
          pa[i] = 6'($urandom);
          pb[i] = 6'($urandom);
          psel[i] = 2'($urandom);
          pcin[i] = 1'($urandom);
        end
      drive_req(0, hold[0], pa[0], pb[0], psel[0], pcin[0]);
      drive_req(1, hold[1], pa[1], pb[1], psel[1], pcin[1]);
      bus.rsp_ready = $urandom_range(99) < pr;
      #1;
      go = !out_busy && (hold[0] || hold[1]);
      w = (hold[0] && hold[1]) ? (tb_last ? 0 : 1) : (hold[1] ? 1 : 0);
      chk("ready0", 32'(bus.req0_ready), 32'(go && w == 0));
      chk("ready1", 32'(bus.req1_ready), 32'(go && w == 1));
      chk("one_ready", 32'(bus.req0_ready && bus.req1_ready), 32'd0);
      chk("busy", 32'(bus.busy), 32'(out_busy));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(out_busy && cyc >= rsp_due));
      if (bus.rsp_valid && bus.rsp_ready && sbq.size() > 0) begin
        s = sbq.pop_front();
        chk("rnd_id", 32'(bus.rsp_id), 32'(s.id));
        chk("rnd_result", 32'(bus.rsp_result), 32'(s.exp[11:0]));
        chk("rnd_carry", 32'(bus.rsp_carry), 32'(s.exp[12]));
        out_busy = 1'b0;
      end
      if (go) begin
        sbq.push_back('{id: w[0], exp: model(pa[w], pb[w], psel[w], pcin[w])});
        rsp_due = cyc + lat(psel[w]) + 1;
        hold[w] = 1'b0;
        tb_last = w[0];
        gseq.push_back(w);
        out_busy = 1'b1;
      end
      step();
    end
  endtask

  // operands feeding the ALU must not move while an op is executing
  logic prev_exec = 1'b0;
  logic [14:0] prev_ops;
  always @(negedge clk) begin
    if (rst_n && bus.busy && !bus.rsp_valid && prev_exec)
      chk("operand_hold", 32'({dut.u_alu.a, dut.u_alu.b, dut.u_alu.sel, dut.u_alu.cin}), 32'(prev_ops));
    prev_exec = rst_n && bus.busy && !bus.rsp_valid;
    prev_ops = {dut.u_alu.a, dut.u_alu.b, dut.u_alu.sel, dut.u_alu.cin};
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got;
    int t;
    vt[0] = '{1'b0, 6'd63, 6'd1,  OP_ADD, 1'b0, 12'h000, 1'b1};
    vt[1] = '{1'b1, 6'd5,  6'd7,  OP_SUB, 1'b0, 12'h03E, 1'b1};
    vt[2] = '{1'b0, 6'h2A, 6'h0F, OP_AND, 1'b0, 12'h00A, 1'b0};
    vt[3] = '{1'b1, 6'd63, 6'd63, OP_MUL, 1'b0, 12'hF81, 1'b0};
    vt[4] = '{1'b0, 6'd10, 6'd3,  OP_SUB, 1'b1, 12'h006, 1'b0};
    vt[5] = '{1'b1, 6'd20, 6'd22, OP_ADD, 1'b1, 12'h02B, 1'b0};
    vt[6] = '{1'b0, 6'd5,  6'd0,  OP_MUL, 1'b1, 12'h000, 1'b0};
    vt[7] = '{1'b1, 6'h3F, 6'h3F, OP_AND, 1'b1, 12'h03F, 1'b0};
    vt[8] = '{1'b0, 6'd0,  6'd0,  OP_SUB, 1'b1, 12'h03F, 1'b1};
    vt[9] = '{1'b1, 6'd40, 6'd23, OP_SUB, 1'b0, 12'h011, 1'b0};
    drive_req(0, 1'b1, 6'd63, 6'd63, OP_MUL, 1'b1);
    drive_req(1, 1'b1, 6'd1, 6'd2, OP_ADD, 1'b0);
    bus.rsp_ready = 1'b1;
    #2;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
    chk("rst_ready1", 32'(bus.req1_ready), 32'd0);
    chk("rst_result", 32'(bus.rsp_result), 32'd0);
    chk("rst_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_carry", 32'(bus.rsp_carry), 32'd0);
    drive_req(0, 1'b0, '0, '0, OP_ADD, 1'b0);
    drive_req(1, 1'b0, '0, '0, OP_ADD, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 10; i++) do_op(vt[i]);

    // stalled response from req1, with both requesters waiting behind it
    bus.rsp_ready = 1'b0;
    drive_req(1, 1'b1, 6'd10, 6'd20, OP_ADD, 1'b0);
    wait_ready(1, got, t);
    chk("stall_accept", 32'(got), 32'd1);
    step();
    drive_req(0, 1'b1, 6'd9, 6'd4, OP_SUB, 1'b0);
    drive_req(1, 1'b1, 6'd1, 6'd2, OP_ADD, 1'b0);
    tb_last = 1'b1;
    for (int i = 0; i < 10 && !bus.rsp_valid; i++) step();
    chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
      chk("stall_result", 32'(bus.rsp_result), 32'h1E);
      chk("stall_id", 32'(bus.rsp_id), 32'd1);
      chk("stall_carry", 32'(bus.rsp_carry), 32'd0);
      chk("stall_busy", 32'(bus.busy), 32'd1);
      chk("stall_rdy", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    step();
    chk("release_valid", 32'(bus.rsp_valid), 32'd0);
    chk("release_busy", 32'(bus.busy), 32'd0);
    wait_ready(0, got, t);
    chk("tie_after_req1", 32'({got, bus.req1_ready}), 32'b10);
    step();
    drive_req(0, 1'b0, '0, '0, OP_ADD, 1'b0);
    finish_rsp(1'b0, 13'h005, t, 1);
    wait_ready(1, got, t);
    chk("req1_served", 32'(got), 32'd1);
    step();
    drive_req(1, 1'b0, '0, '0, OP_ADD, 1'b0);
    finish_rsp(1'b1, 13'h003, t, 1);

    // reset during a MUL's EXEC drops it
    drive_req(0, 1'b1, 6'd63, 6'd63, OP_MUL, 1'b0);
    wait_ready(0, got, t);
    chk("mul_accept", 32'(got), 32'd1);
    step();
    drive_req(0, 1'b0, '0, '0, OP_ADD, 1'b0);
    chk("mul_exec_busy", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    hold[0] = 1'b1; pa[0] = 6'd7; pb[0] = 6'd9; psel[0] = OP_ADD; pcin[0] = 1'b0;
    hold[1] = 1'b1; pa[1] = 6'd3; pb[1] = 6'd5; psel[1] = OP_MUL; pcin[1] = 1'b0;
    drive_req(0, 1'b1, pa[0], pb[0], psel[0], pcin[0]);
    drive_req(1, 1'b1, pa[1], pb[1], psel[1], pcin[1]);
    #1;
    chk("arst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_rdy", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    chk("arst_result", 32'(bus.rsp_result), 32'd0);
    chk("arst_id", 32'(bus.rsp_id), 32'd0);
    step();
    chk("arst_hold_valid", 32'(bus.rsp_valid), 32'd0);
    rst_n = 1'b1;
    tb_last = 1'b1;
    out_busy = 1'b0;
    sbq.delete();
    gseq.delete();
    traffic(14, 100, 100);
    chk("tie_grants", 32'(gseq.size() >= 4), 32'd1);
    if (gseq.size() >= 4)
      for (int k = 0; k < 4; k++) chk("tie_seq", 32'(gseq[k]), 32'(k % 2));

    traffic(3000, 50, 60);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
